// File: rtl/routing_unit.sv
// rtl/routing_unit.sv - 4:1 data router with combinational and registered outputs
// y follows sel with zero latency; the registered copy captures on enabled clock edges.
module routing_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       sel_q,
  output logic [3:0]       sel_oh_q,
  output logic             vld_q
);

  always_comb begin
    y = d0;
    case (sel)
      2'b00: y = d0;
      2'b01: y = d1;
      2'b10: y = d2;
      2'b11: y = d3;
    endcase
  end

  // Once vld_q is set it only returns to 0 through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= '0;
      sel_q    <= 2'b00;
      sel_oh_q <= 4'b0000;
      vld_q    <= 1'b0;
    end else if (en) begin
      y_q      <= y;
      sel_q    <= sel;
      sel_oh_q <= 4'b0001 << sel;
      vld_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_routing_unit.sv
// tb/tb_routing_unit.sv - self-checking bench for routing_unit (WIDTH=4)
// Directed steps followed by randomized traffic against a behavioural model.
module tb_routing_unit;

  logic       clk;
  logic       rst;
  logic [3:0] dv [4];
  logic [1:0] sel;
  logic       en;
  logic [3:0] y;
  logic [3:0] y_q;
  logic [1:0] sel_q;
  logic [3:0] sel_oh_q;
  logic       vld_q;

  int n_checks;
  int n_fails;

  // Reference state for the registered path
  logic [3:0] m_yq;
  logic [1:0] m_sel;
  logic       m_vld;

  routing_unit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .sel(sel), .en(en),
    .y(y), .y_q(y_q), .sel_q(sel_q), .sel_oh_q(sel_oh_q), .vld_q(vld_q)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] s, input logic v);
    logic [3:0] r;
    r = 4'b0000;
    if (v) r[s] = 1'b1;
    return r;
  endfunction

  // One full clock period; model updates at the rising edge from the values present there.
  task automatic tick();
    if (rst) begin
      m_yq = 4'h0; m_sel = 2'b00; m_vld = 1'b0;
    end else if (en) begin
      m_yq = dv[sel]; m_sel = sel; m_vld = 1'b1;
    end
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic chk_reg(input string tag);
    chk({tag, ".y_q"}, 64'(y_q), 64'(m_yq));
    chk({tag, ".sel_q"}, 64'(sel_q), 64'(m_sel));
    chk({tag, ".sel_oh_q"}, 64'(sel_oh_q), 64'(onehot(m_sel, m_vld)));
    chk({tag, ".vld_q"}, 64'(vld_q), 64'(m_vld));
  endtask

  task automatic do_reset_pulse();
    #2 rst = 1'b1;
    #1;
    m_yq = 4'h0; m_sel = 2'b00; m_vld = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clk = 1'b0;
    rst = 1'b0;
    en  = 1'b0;
    sel = 2'b00;
    dv[0] = 4'hA; dv[1] = 4'hB; dv[2] = 4'hC; dv[3] = 4'hD;
    m_yq = 4'h0; m_sel = 2'b00; m_vld = 1'b0;

    // Combinational routing with no clock
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #10;
      chk($sformatf("comb_sel%0d", s), 64'(y), 64'(4'hA + 4'(s)));
    end

    // Asynchronous reset with clock idle
    rst = 1'b1;
    sel = 2'b10;
    #1;
    chk_reg("reset_idle");
    chk("reset_idle.y", 64'(y), 64'hC);

    // rst dominates en
    en = 1'b1;
    tick();
    chk_reg("rst_dominates_en");

    // Registered capture
    rst = 1'b0;
    sel = 2'b01;
    #1;
    tick();
    chk("cap.y_q", 64'(y_q), 64'h B);
    chk("cap.sel_q", 64'(sel_q), 64'h1);
    chk("cap.sel_oh_q", 64'(sel_oh_q), 64'b0010);
    chk("cap.vld_q", 64'(vld_q), 64'h1);
    sel = 2'b11;
    #1;
    chk("cap2.y_now", 64'(y), 64'h D);
    chk("cap2.y_q_before_edge", 64'(y_q), 64'h B);
    tick();
    chk("cap2.y_q_after_edge", 64'(y_q), 64'h D);

    // Enable hold
    sel = 2'b10;
    tick();
    chk("hold.capture", 64'(y_q), 64'h C);
    en = 1'b0;
    sel = 2'b00;
    dv[2] = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d.y_q", i), 64'(y_q), 64'h C);
      chk($sformatf("hold%0d.sel_q", i), 64'(sel_q), 64'h2);
      chk($sformatf("hold%0d.y", i), 64'(y), 64'h A);
    end
    chk_reg("hold_model");

    // Async reset mid-operation
    dv[2] = 4'hC;
    en = 1'b1;
    sel = 2'b11;
    tick();
    chk("mid.pre_y_q", 64'(y_q), 64'h D);
    do_reset_pulse();
    chk_reg("mid.cleared");
    #1 rst = 1'b0;
    sel = 2'b00;
    #1;
    tick();
    chk("mid.resume_y_q", 64'(y_q), 64'h A);
    chk("mid.resume_vld", 64'(vld_q), 64'h1);

    // Data-change sweep on source 3
    sel = 2'b11;
    foreach (dv[k]) begin end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] vals [4];
      vals[0] = 4'h0; vals[1] = 4'hF; vals[2] = 4'h5; vals[3] = 4'hA;
      dv[3] = vals[i];
      #1;
      chk($sformatf("sweep%0d.y", i), 64'(y), 64'(vals[i]));
      tick();
      chk($sformatf("sweep%0d.y_q", i), 64'(y_q), 64'(vals[i]));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) dv[k] = 4'($urandom_range(0, 15));
      sel = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd.y", 64'(y), 64'(dv[sel]));
      tick();
      chk_reg("rnd");
      if (vld_q === 1'b1) begin
        chk("rnd.onehot_count", 64'($countones(sel_oh_q)), 64'h1);
      end
      if ($urandom_range(0, 29) == 0) begin
        do_reset_pulse();
        chk_reg("rnd.async_rst");
        #1 rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
